// File: rtl/ws2811_frame_deserializer.sv
// rtl/ws2811_frame_deserializer.sv - assembles decoded ws2811 bits into a committed NUM_CH-byte frame
//
// Purpose:
//  Takes the decoded ws2811 bit stream and shifts the bits into a shadow
//  register, MSB first. The first byte received goes to channel 0. When
//  'active' falls (line reset), the shadow register is copied to chOut, but
//  only if the frame carried at least NUM_CH*8 bits. A short frame raises
//  frameErr and leaves chOut unchanged.
//
// Ports:
//  masterClk  in   master clock; every port is synchronous to it
//  nReset     in   asynchronous active-low reset
//  dataIn     in   decoded bit, valid on the rising edge of dataClk
//  dataClk    in   bit clock from the decoder
//  active     in   session-active flag from the decoder
//  chOut      out  committed channels; chN = [8N+7:8N]
//  chValid    out  high once any frame has been committed
//  frameDone  out  1-cycle pulse: chOut has just taken a new frame
//  frameErr   out  1-cycle pulse: the frame ended with too few bits
//  overflow   out  the last frame carried more than NUM_CH*8 bits

module ws2811_frame_deserializer #(
    parameter int NUM_CH   = 3,
    parameter int BITCNT_W = $clog2(NUM_CH*8+1)+1
) (
    input  logic                masterClk,
    input  logic                nReset,
    input  logic                dataIn,
    input  logic                dataClk,
    input  logic                active,
    output logic [NUM_CH*8-1:0] chOut,
    output logic                chValid,
    output logic                frameDone,
    output logic                frameErr,
    output logic                overflow
);

    localparam int                  BYTE_W     = BITCNT_W - 3;
    localparam logic [BITCNT_W-1:0] FRAME_BITS = BITCNT_W'(NUM_CH*8);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_RX,
        ST_COMMIT
    } stateT;

    stateT               state;
    logic                prevDataClk;
    logic                prevActive;
    logic [BITCNT_W-1:0] bitCnt;
    logic [NUM_CH*8-1:0] shadow;

    logic bitStrobe;
    logic frameEnd;

    // A strobe needs active high and frameEnd needs active low, so the two
    // can never occur in the same cycle.
    assign bitStrobe = dataClk & ~prevDataClk & active;
    assign frameEnd  = ~active & prevActive;

    always_ff @(posedge masterClk or negedge nReset) begin
        if (!nReset) begin
            state       <= ST_SYNC;
            prevDataClk <= 1'b0;
            prevActive  <= 1'b0;
            bitCnt      <= '0;
            shadow      <= '0;
            chOut       <= '0;
            chValid     <= 1'b0;
            frameDone   <= 1'b0;
            frameErr    <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            prevDataClk <= dataClk;
            prevActive  <= active;
            frameDone   <= 1'b0;
            frameErr    <= 1'b0;

            case (state)
                // Reset may be released in the middle of a frame. Wait for the
                // line reset so that no partial frame is taken as a whole one.
                ST_SYNC: begin
                    if (!active) begin
                        state <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    bitCnt <= '0;
                    shadow <= '0;
                    if (active) begin
                        state    <= ST_RX;
                        overflow <= 1'b0;
                    end
                end

                ST_RX: begin
                    if (bitStrobe) begin
                        if (bitCnt < FRAME_BITS) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (bitCnt[BITCNT_W-1:3] == BYTE_W'(i)) begin
                                    shadow[i*8 +: 8] <= {shadow[i*8 +: 7], dataIn};
                                end
                            end
                        end else begin
                            overflow <= 1'b1;
                        end
                        if (bitCnt != '1) begin
                            bitCnt <= bitCnt + BITCNT_W'(1);
                        end
                    end else if (frameEnd) begin
                        state <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    if (bitCnt >= FRAME_BITS) begin
                        chOut     <= shadow;
                        chValid   <= 1'b1;
                        frameDone <= 1'b1;
                    end else begin
                        frameErr <= 1'b1;
                    end
                    state <= ST_IDLE;
                end

                default: state <= ST_SYNC;
            endcase
        end
    end

endmodule
